// File: rtl/dsp_frame_sequencer.sv
// Frame sequencer: walks each channel of a frame through gain, pipeline tick and mix handshakes.
// Optional per-state watchdog is built when DSP_SEQ_WATCHDOG_EN is defined.
module dsp_frame_sequencer #(
    parameter int unsigned data_width     = 16,
    parameter int unsigned n_channels     = 2,
    parameter int unsigned n_pipelines    = 2,
    parameter int unsigned timeout_cycles = 4096
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [n_channels*data_width-1:0]                    in_frame,
    input  logic                                                sample_ready,
    output logic                                                gain_req,
    output logic [data_width-1:0]                               gain_sample,
    input  logic                                                gain_done,
    output logic                                                pipeline_tick,
    output logic [((n_channels > 1) ? $clog2(n_channels) : 1)-1:0] tick_channel,
    input  logic [n_pipelines-1:0]                              pipelines_ready,
    output logic                                                mix_req,
    input  logic                                                mix_done,
    input  logic [data_width-1:0]                               mix_in,
    output logic [n_channels*data_width-1:0]                    out_frame,
    output logic                                                out_valid,
    output logic                                                ready,
    output logic [31:0]                                         frame_count,
    output logic [15:0]                                         overrun_count,
    input  logic                                                clear_status,
    output logic                                                timeout
);

    localparam int unsigned CH_W = (n_channels > 1) ? $clog2(n_channels) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(n_channels - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAIN,
        S_SETTLE,
        S_PROC,
        S_MIX
    } state_t;

    state_t                state_q, state_d;
    logic [data_width-1:0] in_ch_c    [n_channels];
    logic [data_width-1:0] frame_q    [n_channels];
    logic [data_width-1:0] frame_d    [n_channels];
    logic [data_width-1:0] out_ch_q   [n_channels];
    logic [data_width-1:0] out_ch_d   [n_channels];
    logic [CH_W-1:0]       chan_q, chan_d, chan_next_c;
    logic [CH_W-1:0]       tick_channel_q, tick_channel_d;
    logic [data_width-1:0] gain_sample_q, gain_sample_d;
    logic                  gain_req_q, gain_req_d;
    logic                  pipeline_tick_q, pipeline_tick_d;
    logic                  mix_req_q, mix_req_d;
    logic                  out_valid_q, out_valid_d;
    logic                  ready_q, ready_d;
    logic                  timeout_q, timeout_d;
    logic [31:0]           frame_count_q, frame_count_d;
    logic [15:0]           overrun_count_q, overrun_count_d;
    logic                  event_c;
    logic                  wd_fire_c;

    // Channel views of the flat input/output frame buses
    for (genvar g = 0; g < n_channels; g++) begin : g_chan
        assign in_ch_c[g] = in_frame[g*data_width +: data_width];
        assign out_frame[g*data_width +: data_width] = out_ch_q[g];
    end

    assign chan_next_c = chan_q + CH_W'(1);

    always_comb begin
        event_c = 1'b0;
        case (state_q)
            S_GAIN:  event_c = gain_done;
            S_PROC:  event_c = &pipelines_ready;
            S_MIX:   event_c = mix_done;
            default: event_c = 1'b0;
        endcase
    end

`ifdef DSP_SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(timeout_cycles + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            waiting_c;

    assign waiting_c = (state_q == S_GAIN) || (state_q == S_PROC) || (state_q == S_MIX);
    assign wd_fire_c = waiting_c && !event_c && (wd_q == WD_W'(timeout_cycles - 1));

    // Reload on every state change so each wait state gets a full budget
    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (waiting_c && !event_c) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    logic wd_unused;
    assign wd_unused = ^32'(timeout_cycles);
    assign wd_fire_c = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        frame_d         = frame_q;
        out_ch_d        = out_ch_q;
        chan_d          = chan_q;
        tick_channel_d  = tick_channel_q;
        gain_sample_d   = gain_sample_q;
        gain_req_d      = 1'b0;
        pipeline_tick_d = 1'b0;
        mix_req_d       = 1'b0;
        out_valid_d     = 1'b0;
        ready_d         = ready_q;
        timeout_d       = timeout_q;
        frame_count_d   = frame_count_q;
        overrun_count_d = overrun_count_q;

        if (sample_ready && (state_q != S_IDLE) && (overrun_count_q != 16'hFFFF)) begin
            overrun_count_d = overrun_count_q + 16'd1;
        end
        if (clear_status) begin
            overrun_count_d = 16'd0;
            timeout_d       = 1'b0;
        end
        if (wd_fire_c) begin
            timeout_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (sample_ready) begin
                    frame_d       = in_ch_c;
                    chan_d        = '0;
                    ready_d       = 1'b0;
                    gain_req_d    = 1'b1;
                    gain_sample_d = in_ch_c[0];
                    state_d       = S_GAIN;
                end
            end
            S_GAIN: begin
                if (gain_done || wd_fire_c) begin
                    pipeline_tick_d = 1'b1;
                    tick_channel_d  = chan_q;
                    state_d         = S_SETTLE;
                end
            end
            S_SETTLE: begin
                state_d = S_PROC;
            end
            S_PROC: begin
                if ((&pipelines_ready) || wd_fire_c) begin
                    mix_req_d = 1'b1;
                    state_d   = S_MIX;
                end
            end
            S_MIX: begin
                if (mix_done || wd_fire_c) begin
                    // A watchdog-forced exit keeps the previous sample for this channel
                    if (mix_done) begin
                        out_ch_d[chan_q] = mix_in;
                    end
                    if (chan_q == LAST_CH) begin
                        out_valid_d   = 1'b1;
                        ready_d       = 1'b1;
                        frame_count_d = frame_count_q + 32'd1;
                        state_d       = S_IDLE;
                    end else begin
                        chan_d        = chan_next_c;
                        gain_req_d    = 1'b1;
                        gain_sample_d = frame_q[chan_next_c];
                        state_d       = S_GAIN;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_IDLE;
            frame_q         <= '{default: '0};
            out_ch_q        <= '{default: '0};
            chan_q          <= '0;
            tick_channel_q  <= '0;
            gain_sample_q   <= '0;
            gain_req_q      <= 1'b0;
            pipeline_tick_q <= 1'b0;
            mix_req_q       <= 1'b0;
            out_valid_q     <= 1'b0;
            ready_q         <= 1'b1;
            timeout_q       <= 1'b0;
            frame_count_q   <= 32'd0;
            overrun_count_q <= 16'd0;
        end else begin
            state_q         <= state_d;
            frame_q         <= frame_d;
            out_ch_q        <= out_ch_d;
            chan_q          <= chan_d;
            tick_channel_q  <= tick_channel_d;
            gain_sample_q   <= gain_sample_d;
            gain_req_q      <= gain_req_d;
            pipeline_tick_q <= pipeline_tick_d;
            mix_req_q       <= mix_req_d;
            out_valid_q     <= out_valid_d;
            ready_q         <= ready_d;
            timeout_q       <= timeout_d;
            frame_count_q   <= frame_count_d;
            overrun_count_q <= overrun_count_d;
        end
    end

    assign gain_req      = gain_req_q;
    assign gain_sample   = gain_sample_q;
    assign pipeline_tick = pipeline_tick_q;
    assign tick_channel  = tick_channel_q;
    assign mix_req       = mix_req_q;
    assign out_valid     = out_valid_q;
    assign ready         = ready_q;
    assign frame_count   = frame_count_q;
    assign overrun_count = overrun_count_q;
    assign timeout       = timeout_q;

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// Bench for dsp_frame_sequencer: table-driven frames with a scoreboard, plus stall, overrun,
// saturation, reset-abort and watchdog sequences (watchdog path follows DSP_SEQ_WATCHDOG_EN).
module tb_dsp_frame_sequencer;

    typedef struct {
        logic [31:0] f;
        logic [15:0] add;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] frame;
        logic [31:0] fc;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_frame;
    logic        sample_ready;
    logic        gain_req;
    logic [15:0] gain_sample;
    logic        gain_done;
    logic        pipeline_tick;
    logic [0:0]  tick_channel;
    logic [1:0]  pipelines_ready;
    logic        mix_req;
    logic        mix_done;
    logic [15:0] mix_in;
    logic [31:0] out_frame;
    logic        out_valid;
    logic        ready;
    logic [31:0] frame_count;
    logic [15:0] overrun_count;
    logic        clear_status;
    logic        timeout;

    logic [1:0]  pr_val;
    logic        auto_mix;
    logic        man_mix;
    logic [15:0] mix_add;
    logic        sb_en;
    logic [31:0] fc_model;
    logic [31:0] last_out;
    int          n_vec = 0;
    int          n_err = 0;
    sb_t         sb[$];
    vec_t        vecs[5];

    // Zero-latency responders; the mixer echoes the gained sample plus an offset
    assign gain_done       = gain_req;
    assign mix_done        = (auto_mix & mix_req) | man_mix;
    assign mix_in          = gain_sample + mix_add;
    assign pipelines_ready = pr_val;

    dsp_frame_sequencer #(
        .data_width     (16),
        .n_channels     (2),
        .n_pipelines    (2),
        .timeout_cycles (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .in_frame        (in_frame),
        .sample_ready    (sample_ready),
        .gain_req        (gain_req),
        .gain_sample     (gain_sample),
        .gain_done       (gain_done),
        .pipeline_tick   (pipeline_tick),
        .tick_channel    (tick_channel),
        .pipelines_ready (pipelines_ready),
        .mix_req         (mix_req),
        .mix_done        (mix_done),
        .mix_in          (mix_in),
        .out_frame       (out_frame),
        .out_valid       (out_valid),
        .ready           (ready),
        .frame_count     (frame_count),
        .overrun_count   (overrun_count),
        .clear_status    (clear_status),
        .timeout         (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return out_valid;
            1:       return pipeline_tick;
            default: return ready;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int budget, output int n);
        n = 0;
        while (n < budget && !sig(sel)) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic push_exp(input logic [31:0] exp);
        fc_model = fc_model + 32'd1;
        sb.push_back('{exp, fc_model});
        last_out = exp;
    endtask

    task automatic start_frame(input logic [31:0] f);
        in_frame     = f;
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        in_frame     = ~f;
    endtask

    task automatic run_frame(input logic [31:0] f, input logic [15:0] add,
                             input logic [31:0] exp, input string nm);
        int n;
        mix_add = add;
        push_exp(exp);
        start_frame(f);
        wait_sig(0, 200, n);
        chk({nm, " latency"}, 64'(n + 1), 64'd9);
        chk({nm, " ready"}, 64'(ready), 64'd1);
        @(posedge clk);
        #1;
        chk({nm, " out_valid width"}, 64'(out_valid), 64'd0);
    endtask

    // Scoreboard consumer: every out_valid must match the oldest expected frame
    always @(negedge clk) begin
        if (!reset && out_valid && sb_en) begin
            if (sb.size() == 0) begin
                chk("unexpected out_valid", 64'(out_valid), 64'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("out_frame", 64'(out_frame), 64'(e.frame));
                chk("frame_count", 64'(frame_count), 64'(e.fc));
            end
        end
    end

    initial begin
        int n;
        int cnt;
        vecs[0] = '{32'h0200_0100, 16'h0000, 32'h0200_0100};
        vecs[1] = '{32'hFFFF_0001, 16'h0001, 32'h0000_0002};
        vecs[2] = '{32'h1234_ABCD, 16'h1111, 32'h2345_BCDE};
        vecs[3] = '{32'h0000_0000, 16'hFFFF, 32'hFFFF_FFFF};
        vecs[4] = '{32'h8000_7FFF, 16'h8000, 32'h0000_FFFF};

        reset = 1'b0; sample_ready = 1'b0; in_frame = '0; clear_status = 1'b0;
        pr_val = 2'b11; auto_mix = 1'b1; man_mix = 1'b0; mix_add = '0;
        sb_en = 1'b1; fc_model = '0; last_out = '0;
        #1 reset = 1'b1;
        #2;
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset pulses", 64'({gain_req, pipeline_tick, mix_req, out_valid, timeout}), 64'd0);
        chk("reset out_frame", 64'(out_frame), 64'd0);
        chk("reset counts", 64'({frame_count, overrun_count}), 64'd0);
        chk("reset gain_sample", 64'({tick_channel, gain_sample}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].f, vecs[i].add, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Pipelines not all ready: mix_req held off, then issued one cycle after release
        mix_add = 16'h0000;
        pr_val  = 2'b01;
        push_exp(32'hCAFE_BEEF);
        start_frame(32'hCAFE_BEEF);
        wait_sig(1, 20, n);
        chk("stall tick seen", 64'(pipeline_tick), 64'd1);
        cnt = 0;
`ifdef DSP_SEQ_WATCHDOG_EN
        repeat (12) begin
`else
        repeat (20) begin
`endif
            @(posedge clk);
            #1;
            if (mix_req) cnt++;
        end
        chk("stall no mix_req", 64'(cnt), 64'd0);
        pr_val = 2'b11;
        @(posedge clk);
        #1;
        chk("stall mix_req on release", 64'(mix_req), 64'd1);
        @(posedge clk);
        #1;
        chk("stall mix_req width", 64'(mix_req), 64'd0);
        wait_sig(0, 50, n);
        chk("stall frame done", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Overruns during processing; clear wins over a simultaneous overrun
        mix_add = 16'h0101;
        pr_val  = 2'b00;
        push_exp(32'h5656_ABAB);
        start_frame(32'h5555_AAAA);
        wait_sig(1, 20, n);
        for (int k = 0; k < 3; k++) begin
            in_frame     = $urandom;
            sample_ready = 1'b1;
            @(posedge clk);
            #1;
            sample_ready = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("overrun count 3", 64'(overrun_count), 64'd3);
        sample_ready = 1'b1;
        clear_status = 1'b1;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        clear_status = 1'b0;
        chk("clear wins", 64'(overrun_count), 64'd0);
        pr_val = 2'b11;
        wait_sig(0, 50, n);
        chk("overrun frame done", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;

        // sample_ready in the MIX cycle that returns to IDLE is an overrun
        mix_add = 16'h0000;
        push_exp(32'h0F0F_F0F0);
        start_frame(32'h0F0F_F0F0);
        repeat (7) @(posedge clk);
        #1;
        in_frame     = 32'hDEAD_BEEF;
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        sample_ready = 1'b0;
        chk("last-mix out_valid", 64'(out_valid), 64'd1);
        chk("last-mix overrun", 64'(overrun_count), 64'd1);
        chk("last-mix no accept", 64'({gain_req, ready}), 64'b01);
        clear_status = 1'b1;
        @(posedge clk);
        #1;
        clear_status = 1'b0;
        chk("clear_status", 64'(overrun_count), 64'd0);

        // Saturation: strobe every cycle while the pipelines hold processing
        sb_en        = 1'b0;
        pr_val       = 2'b00;
        in_frame     = '0;
        sample_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        sample_ready = 1'b0;
        chk("overrun saturate", 64'(overrun_count), 64'hFFFF);
        pr_val = 2'b11;
        wait_sig(2, 200, n);
        @(posedge clk);
        #1;
        sb_en = 1'b1;

        // Reset in PROC aborts the frame immediately
        pr_val = 2'b00;
        start_frame(32'h1111_2222);
        wait_sig(1, 20, n);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("abort ready", 64'(ready), 64'd1);
        chk("abort pulses", 64'({gain_req, pipeline_tick, mix_req, out_valid, timeout}), 64'd0);
        chk("abort out_frame", 64'(out_frame), 64'd0);
        chk("abort counts", 64'({frame_count, overrun_count}), 64'd0);
        chk("abort gain_sample", 64'({tick_channel, gain_sample}), 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        fc_model = '0;
        pr_val   = 2'b11;
        cnt      = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        chk("abort no out_valid", 64'(cnt), 64'd0);
        run_frame(vecs[2].f, vecs[2].add, vecs[2].exp, "post-reset");

        // Mixer never answers
        auto_mix = 1'b0;
        mix_add  = 16'h0000;
`ifdef DSP_SEQ_WATCHDOG_EN
        begin
            int   lat;
            logic t19;
            logic t20;
            lat = 0; t19 = 1'bx; t20 = 1'bx;
            push_exp(last_out);
            start_frame(32'h7777_8888);
            n = 1;
            while (n <= 100 && lat == 0) begin
                if (n == 19) t19 = timeout;
                if (n == 20) t20 = timeout;
                if (out_valid) lat = n;
                else begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
            chk("wd latency", 64'(lat), 64'd39);
            chk("wd timeout before limit", 64'(t19), 64'd0);
            chk("wd timeout after limit", 64'(t20), 64'd1);
            @(posedge clk);
            #1;
            clear_status = 1'b1;
            @(posedge clk);
            #1;
            clear_status = 1'b0;
            chk("wd timeout cleared", 64'(timeout), 64'd0);
        end
`else
        push_exp(32'h7777_8888);
        start_frame(32'h7777_8888);
        cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        chk("no-wd stuck in MIX", 64'(cnt), 64'd0);
        chk("no-wd timeout", 64'(timeout), 64'd0);
        man_mix  = 1'b1;
        auto_mix = 1'b1;
        @(posedge clk);
        #1;
        man_mix = 1'b0;
        wait_sig(0, 30, n);
        chk("no-wd frame done", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
`endif
        auto_mix = 1'b1;
        chk("scoreboard drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
